// File: rtl/stopwatch_load_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stopwatch_load_ctrl
//   Turns preset/add/subtract button events into BCD load requests for a
//   stopwatch counter, clamped to [PRESET_LO, PRESET_HI].
// Revision: 1.0
// ---------------------------------------------------------------------------
module stopwatch_load_ctrl #(
  parameter logic [15:0] PRESET_LO = 16'h1020,
  parameter logic [15:0] PRESET_HI = 16'h4030
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [16:1] Q,
  input  logic        REVERSE,
  input  logic        RESET,
  input  logic        ADD,
  input  logic        SUBTRACT,
  output logic        LOAD,
  output logic [16:1] VALUE,
  output logic        LIMIT
);

  function automatic logic [3:0] sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Bit order in the edge detectors: {RESET, ADD, SUBTRACT}
  logic [2:0]  smp_q, smp_d;
  logic [2:0]  prv_q, prv_d;
  logic        load_q, load_d;
  logic [16:1] value_q, value_d;
  logic        limit_q, limit_d;

  logic [2:0]  ev;
  logic [3:0]  mt, mo, st, so;
  logic [4:0]  inc_mt;
  logic [3:0]  inc_mo, dec_mt, dec_mo;
  logic        dec_unf;
  logic [15:0] add_val, sub_val;

  always_comb begin
    smp_d = {RESET, ADD, SUBTRACT};
    prv_d = smp_q;
    ev    = smp_q & ~prv_q;

    mt = sat9(Q[16:13]);
    mo = sat9(Q[12:9]);
    st = sat9(Q[8:5]);
    so = sat9(Q[4:1]);

    inc_mt = {1'b0, mt};
    inc_mo = mo + 4'd1;
    if (mo == 4'd9) begin
      inc_mo = 4'd0;
      inc_mt = {1'b0, mt} + 5'd1;
    end
    add_val = {inc_mt[3:0], inc_mo, st, so};

    dec_mt  = mt;
    dec_mo  = mo - 4'd1;
    dec_unf = 1'b0;
    if (mo == 4'd0) begin
      dec_mo  = 4'd9;
      dec_mt  = mt - 4'd1;
      dec_unf = (mt == 4'd0);
    end
    sub_val = {dec_mt, dec_mo, st, so};

    load_d  = 1'b0;
    value_d = value_q;
    limit_d = limit_q;
    if (ev[2]) begin
      load_d  = 1'b1;
      value_d = REVERSE ? PRESET_HI : PRESET_LO;
      limit_d = 1'b0;
    end else if (ev[1] && ev[0]) begin
      // Conflicting minute requests cancel each other out
      load_d = 1'b0;
    end else if (ev[1]) begin
      load_d = 1'b1;
      if (inc_mt > 5'd9 || add_val > PRESET_HI) begin
        value_d = PRESET_HI;
        limit_d = 1'b1;
      end else begin
        value_d = add_val;
        limit_d = 1'b0;
      end
    end else if (ev[0]) begin
      load_d = 1'b1;
      if (dec_unf || sub_val < PRESET_LO) begin
        value_d = PRESET_LO;
        limit_d = 1'b1;
      end else begin
        value_d = sub_val;
        limit_d = 1'b0;
      end
    end
  end

  // Edge detectors reset high so a button held through reset is not an event
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      smp_q   <= '1;
      prv_q   <= '1;
      load_q  <= 1'b0;
      value_q <= PRESET_LO;
      limit_q <= 1'b0;
    end else begin
      smp_q   <= smp_d;
      prv_q   <= prv_d;
      load_q  <= load_d;
      value_q <= value_d;
      limit_q <= limit_d;
    end
  end

  assign LOAD  = load_q;
  assign VALUE = value_q;
  assign LIMIT = limit_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_load_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stopwatch_load_ctrl
//   Directed self-checking bench for stopwatch_load_ctrl.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_stopwatch_load_ctrl;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [15:0] Q;
  logic        REVERSE, RESET, ADD, SUBTRACT;
  logic        LOAD, LIMIT;
  logic [15:0] VALUE;

  int checks = 0;
  int errors = 0;

  logic        o_early, o_ld, o_after, o_lim;
  logic [15:0] o_val;

  stopwatch_load_ctrl dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .Q       (Q),
    .REVERSE (REVERSE),
    .RESET   (RESET),
    .ADD     (ADD),
    .SUBTRACT(SUBTRACT),
    .LOAD    (LOAD),
    .VALUE   (VALUE),
    .LIMIT   (LIMIT)
  );

  always #5 clk_in = ~clk_in;

  // Drives a one-cycle pulse from a falling edge and records LOAD over the
  // following three falling edges (strobe expected on the second).
  task automatic pulse(input logic r, input logic a, input logic s);
    RESET = r; ADD = a; SUBTRACT = s;
    @(negedge clk_in);
    RESET = 1'b0; ADD = 1'b0; SUBTRACT = 1'b0;
    o_early = LOAD;
    @(negedge clk_in);
    o_ld = LOAD; o_val = VALUE; o_lim = LIMIT;
    @(negedge clk_in);
    o_after = LOAD;
  endtask

  task automatic test_reset;
    rst = 1'b1; Q = 16'h0000; REVERSE = 1'b0;
    RESET = 1'b0; ADD = 1'b0; SUBTRACT = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (LOAD !== 1'b0) begin
      errors++; $display("FAIL reset_load: got %b want 0", LOAD);
    end
    checks++;
    if (VALUE !== 16'h1020) begin
      errors++; $display("FAIL reset_value: got %h want 1020", VALUE);
    end
    checks++;
    if (LIMIT !== 1'b0) begin
      errors++; $display("FAIL reset_limit: got %b want 0", LIMIT);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  typedef struct {
    logic [15:0] q;
    logic        rev, r, a, s;
    logic [15:0] val;
    logic        lim;
  } vec_t;

  task automatic test_arith;
    vec_t v[9];
    v[0] = '{16'h1020, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1120, 1'b0};
    v[1] = '{16'h1945, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2045, 1'b0};
    v[2] = '{16'h2000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1900, 1'b0};
    v[3] = '{16'h4015, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4030, 1'b1};
    v[4] = '{16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1334, 1'b0};
    v[5] = '{16'h1010, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1020, 1'b1};
    v[6] = '{16'h1A3F, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2039, 1'b0};
    v[7] = '{16'h3558, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3458, 1'b0};
    v[8] = '{16'h0030, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1020, 1'b1};
    for (int i = 0; i < 9; i++) begin
      Q = v[i].q; REVERSE = v[i].rev;
      pulse(v[i].r, v[i].a, v[i].s);
      checks++;
      if ({o_early, o_ld, o_after} !== 3'b010 || o_val !== v[i].val || o_lim !== v[i].lim) begin
        errors++;
        $display("FAIL arith_%0d q=%h: load seq=%b val=%h lim=%b, want seq=010 val=%h lim=%b",
                 i, v[i].q, {o_early, o_ld, o_after}, o_val, o_lim, v[i].val, v[i].lim);
      end
    end
    // Outputs must hold steady after the strobe
    Q = 16'h2222;
    repeat (4) @(negedge clk_in);
    checks++;
    if (LOAD !== 1'b0 || VALUE !== 16'h1020 || LIMIT !== 1'b1) begin
      errors++;
      $display("FAIL value_hold: load=%b val=%h lim=%b, want 0 1020 1", LOAD, VALUE, LIMIT);
    end
  endtask

  task automatic test_preset;
    vec_t v[3];
    v[0] = '{16'h2000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4030, 1'b0};
    v[1] = '{16'h2000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1020, 1'b0};
    v[2] = '{16'h2000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4030, 1'b0};
    for (int i = 0; i < 3; i++) begin
      Q = v[i].q; REVERSE = v[i].rev;
      pulse(v[i].r, v[i].a, v[i].s);
      checks++;
      if ({o_early, o_ld, o_after} !== 3'b010 || o_val !== v[i].val || o_lim !== v[i].lim) begin
        errors++;
        $display("FAIL preset_%0d rev=%b: load seq=%b val=%h lim=%b, want seq=010 val=%h lim=%b",
                 i, v[i].rev, {o_early, o_ld, o_after}, o_val, o_lim, v[i].val, v[i].lim);
      end
    end
    REVERSE = 1'b0;
  endtask

  task automatic test_hold_and_conflict;
    int n;
    Q = 16'h1500;
    n = 0;
    ADD = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (LOAD === 1'b1) n++;
    end
    ADD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      if (LOAD === 1'b1) n++;
    end
    checks++;
    if (n != 1 || VALUE !== 16'h1600) begin
      errors++; $display("FAIL add_held: loads=%0d val=%h, want 1 1600", n, VALUE);
    end
    n = 0;
    ADD = 1'b1; SUBTRACT = 1'b1;
    @(negedge clk_in);
    ADD = 1'b0; SUBTRACT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      if (LOAD === 1'b1) n++;
    end
    checks++;
    if (n != 0 || VALUE !== 16'h1600) begin
      errors++; $display("FAIL add_sub_together: loads=%0d val=%h, want 0 1600", n, VALUE);
    end
  endtask

  task automatic test_rst_mid;
    int n;
    Q = 16'h1020;
    ADD = 1'b1;
    @(negedge clk_in);
    // Event is pending here; reset must cancel it without waiting for a clock
    rst = 1'b1;
    #1;
    checks++;
    if (LOAD !== 1'b0 || VALUE !== 16'h1020 || LIMIT !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: load=%b val=%h lim=%b, want 0 1020 0", LOAD, VALUE, LIMIT);
    end
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      if (LOAD === 1'b1) n++;
    end
    ADD = 1'b0;
    checks++;
    if (n != 0 || VALUE !== 16'h1020) begin
      errors++; $display("FAIL add_high_at_release: loads=%0d val=%h, want 0 1020", n, VALUE);
    end
    @(negedge clk_in);
    pulse(1'b0, 1'b1, 1'b0);
    checks++;
    if ({o_early, o_ld, o_after} !== 3'b010 || o_val !== 16'h1120) begin
      errors++;
      $display("FAIL add_after_release: load seq=%b val=%h, want 010 1120",
               {o_early, o_ld, o_after}, o_val);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_preset();
    test_hold_and_conflict();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
